// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined fixed-point multiplier: per-operand signedness, post-multiply shift with optional
// rounding, wrap or saturate narrowing with overflow flag, clock enable and valid tracking.
module myproject_mul_pipe_sat #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 2,
   parameter int din0_WIDTH  = 22,
   parameter int din1_WIDTH  = 19,
   parameter int dout_WIDTH  = 41,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 0,
   parameter int SHIFT       = 0,
   parameter int ROUND       = 0,
   parameter int SAT         = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  din_valid,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  dout_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int P   = din0_WIDTH + din1_WIDTH;
   // Two guard bits: one for the rounding add, one so 2^P (unsigned W=P bound) stays positive.
   localparam int XW  = P + 2;
   localparam bit OSIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [XW-1:0] ONE  = XW'(1);
   localparam logic signed [XW-1:0] MAXV = OSIGNED ? (ONE <<< (dout_WIDTH - 1)) - ONE
                                                   : (ONE <<< dout_WIDTH) - ONE;
   localparam logic signed [XW-1:0] MINV = OSIGNED ? -(ONE <<< (dout_WIDTH - 1)) : '0;
   localparam logic signed [XW-1:0] RADD = ((ROUND != 0) && (SHIFT > 0)) ? (ONE <<< RSH) : '0;

   logic [din0_WIDTH-1:0]      a_m;
   logic [din1_WIDTH-1:0]      b_m;
   logic signed [din0_WIDTH:0] a_x;
   logic signed [din1_WIDTH:0] b_x;
   logic signed [P:0]          prod;
   logic signed [P:0]          prod_m;
   logic signed [XW-1:0]       sum;
   logic signed [XW-1:0]       sh;
   logic                       hi;
   logic                       lo;
   logic [dout_WIDTH-1:0]      res;
   logic [NUM_STAGE-1:0]       vld_q;
   logic [dout_WIDTH-1:0]      dout_q;
   logic                       ovf_q;

   generate
      if (NUM_STAGE >= 2) begin : g_opreg
         logic [din0_WIDTH-1:0] a_q;
         logic [din1_WIDTH-1:0] b_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               a_q <= '0;
               b_q <= '0;
            end else if (ce) begin
               a_q <= din0;
               b_q <= din1;
            end
         end
         assign a_m = a_q;
         assign b_m = b_q;
      end else begin : g_opcomb
         assign a_m = din0;
         assign b_m = din1;
      end
   endgenerate

   assign a_x  = {(DIN0_SIGNED != 0) & a_m[din0_WIDTH-1], a_m};
   assign b_x  = {(DIN1_SIGNED != 0) & b_m[din1_WIDTH-1], b_m};
   assign prod = (P + 1)'(a_x) * (P + 1)'(b_x);

   generate
      if (NUM_STAGE >= 3) begin : g_prodreg
         localparam int ND = NUM_STAGE - 2;
         logic signed [P:0] pd_q [ND];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < ND; i++) pd_q[i] <= '0;
            end else if (ce) begin
               pd_q[0] <= prod;
               for (int i = 1; i < ND; i++) pd_q[i] <= pd_q[i-1];
            end
         end
         assign prod_m = pd_q[ND-1];
      end else begin : g_prodcomb
         assign prod_m = prod;
      end
   endgenerate

   // Unsigned products are never negative, so the arithmetic shift equals a logical one there.
   always_comb begin
      sum = XW'(prod_m) + RADD;
      sh  = sum >>> SHIFT;
      hi  = sh > MAXV;
      lo  = sh < MINV;
      res = sh[dout_WIDTH-1:0];
      if (SAT != 0) begin
         if (hi) begin
            res = MAXV[dout_WIDTH-1:0];
         end else if (lo) begin
            res = MINV[dout_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
         vld_q  <= '0;
      end else if (ce) begin
         dout_q   <= res;
         ovf_q    <= hi | lo;
         vld_q[0] <= din_valid;
         for (int i = 1; i < NUM_STAGE; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   assign dout       = dout_q;
   assign ovf        = ovf_q;
   assign dout_valid = vld_q[NUM_STAGE-1];

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// Bench for myproject_mul_pipe_sat: seven configurations share one stimulus stream and are
// compared each cycle against an integer reference model; directed cases pin known results.
module tb_myproject_mul_pipe_sat;

   localparam int NI = 7;
   localparam int HN = 4096;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        din_valid;
   logic [21:0] din0;
   logic [18:0] din1;

   logic        dv_w [NI];
   logic        ov_w [NI];
   logic [63:0] dd_w [NI];
   logic [40:0] d0, d5;
   logic [15:0] d1, d2, d3, d4;
   logic [7:0]  d6;

   int st_c  [NI] = '{2, 1, 4, 2, 3, 3, 2};
   int w_c   [NI] = '{41, 16, 16, 16, 16, 41, 8};
   int s0_c  [NI] = '{1, 1, 1, 1, 1, 1, 0};
   int s1_c  [NI] = '{0, 1, 1, 1, 1, 0, 0};
   int sh_c  [NI] = '{0, 0, 0, 4, 4, 0, 0};
   int rn_c  [NI] = '{0, 0, 0, 1, 0, 0, 0};
   int sat_c [NI] = '{0, 1, 0, 0, 0, 0, 1};

   // Inputs accepted on each ce=1 edge since the last reset, indexed from 1.
   logic        hv [HN];
   logic [21:0] ha [HN];
   logic [18:0] hb [HN];
   int          n;

   int n_chk;
   int n_pass;

   myproject_mul_pipe_sat #(.NUM_STAGE(2)) u0 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[0]), .dout(d0), .ovf(ov_w[0]));
   myproject_mul_pipe_sat #(.NUM_STAGE(1), .dout_WIDTH(16), .DIN1_SIGNED(1), .SAT(1)) u1 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[1]), .dout(d1), .ovf(ov_w[1]));
   myproject_mul_pipe_sat #(.NUM_STAGE(4), .dout_WIDTH(16), .DIN1_SIGNED(1), .SAT(0)) u2 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[2]), .dout(d2), .ovf(ov_w[2]));
   myproject_mul_pipe_sat #(.NUM_STAGE(2), .dout_WIDTH(16), .DIN1_SIGNED(1), .SHIFT(4),
                            .ROUND(1)) u3 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[3]), .dout(d3), .ovf(ov_w[3]));
   myproject_mul_pipe_sat #(.NUM_STAGE(3), .dout_WIDTH(16), .DIN1_SIGNED(1), .SHIFT(4),
                            .ROUND(0)) u4 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[4]), .dout(d4), .ovf(ov_w[4]));
   myproject_mul_pipe_sat #(.NUM_STAGE(3)) u5 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[5]), .dout(d5), .ovf(ov_w[5]));
   myproject_mul_pipe_sat #(.NUM_STAGE(2), .dout_WIDTH(8), .DIN0_SIGNED(0), .DIN1_SIGNED(0),
                            .SAT(1)) u6 (
      .clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid), .din0(din0), .din1(din1),
      .dout_valid(dv_w[6]), .dout(d6), .ovf(ov_w[6]));

   assign dd_w[0] = 64'(d0);
   assign dd_w[1] = 64'(d1);
   assign dd_w[2] = 64'(d2);
   assign dd_w[3] = 64'(d3);
   assign dd_w[4] = 64'(d4);
   assign dd_w[5] = 64'(d5);
   assign dd_w[6] = 64'(d6);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product, floor shift (after optional +half), then range clamp/wrap.
   function automatic void model(input int i, input logic [21:0] a, input logic [18:0] b,
                                 output logic [63:0] d, output logic o);
      longint x, y, p, mx, mn, v;
      x = (s0_c[i] != 0) ? longint'($signed(a)) : longint'(a);
      y = (s1_c[i] != 0) ? longint'($signed(b)) : longint'(b);
      p = x * y;
      if (rn_c[i] != 0 && sh_c[i] > 0) p = p + (longint'(1) <<< (sh_c[i] - 1));
      p = p >>> sh_c[i];
      if (s0_c[i] != 0 || s1_c[i] != 0) begin
         mx = (longint'(1) <<< (w_c[i] - 1)) - 1;
         mn = -mx - 1;
      end else begin
         mx = (longint'(1) <<< w_c[i]) - 1;
         mn = 0;
      end
      o = (p > mx) || (p < mn);
      v = p;
      if (sat_c[i] != 0) begin
         if (p > mx) v = mx;
         else if (p < mn) v = mn;
      end
      d = 64'(v) & ((64'd1 << w_c[i]) - 64'd1);
   endfunction

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         int          k;
         logic        ev;
         logic        eo;
         logic [63:0] ed;
         k = n - st_c[i] + 1;
         if (k < 1) begin
            ev = 1'b0;
            eo = 1'b0;
            ed = '0;
         end else begin
            ev = hv[k];
            model(i, ha[k], hb[k], ed, eo);
         end
         check($sformatf("u%0d valid", i), 64'(dv_w[i]), 64'(ev));
         if (k < 1 || ev) begin
            check($sformatf("u%0d dout", i), dd_w[i], ed);
            check($sformatf("u%0d ovf", i), 64'(ov_w[i]), 64'(eo));
         end
      end
   endtask

   task automatic step(input logic c, input logic v, input logic [21:0] a, input logic [18:0] b);
      @(negedge clk);
      check_all();
      ce        = c;
      din_valid = v;
      din0      = a;
      din1      = b;
      @(posedge clk);
      if (c && n < HN - 1) begin
         n++;
         hv[n] = v;
         ha[n] = a;
         hb[n] = b;
      end
   endtask

   function automatic logic [21:0] rnd_a();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return 22'(r);
         1:       return {{15{r[6]}}, r[6:0]};
         2:       return (r[1:0] == 2'd0) ? 22'h200000 : (r[1:0] == 2'd1) ? 22'h1FFFFF :
                         (r[1:0] == 2'd2) ? 22'h3FFFFF : 22'h000000;
         default: return 22'(r[9:0]);
      endcase
   endfunction

   function automatic logic [18:0] rnd_b();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0:       return 19'(r);
         1:       return {{12{r[6]}}, r[6:0]};
         2:       return (r[1:0] == 2'd0) ? 19'h40000 : (r[1:0] == 2'd1) ? 19'h3FFFF :
                         (r[1:0] == 2'd2) ? 19'h7FFFF : 19'h00000;
         default: return 19'(r[9:0]);
      endcase
   endfunction

   logic        sv_exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic [40:0] sd_exp [4] = '{41'd1, 41'd6, 41'd0, 41'd20};

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      n         = 0;
      reset     = 1'b1;
      ce        = 1'b0;
      din_valid = 1'b0;
      din0      = '0;
      din1      = '0;
      @(negedge clk);
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // Defaults: -1 x 524287 after two edges.
      step(1'b1, 1'b1, 22'h3FFFFF, 19'h7FFFF);
      step(1'b1, 1'b0, 22'h0, 19'h0);
      #1;
      check("default dout", 64'(d0), 64'h1FFFFF80001);
      check("default valid", 64'(dv_w[0]), 64'd1);
      check("default ovf", 64'(ov_w[0]), 64'd0);

      // Saturation (u1, latency 1) and wrap (u2, latency 4) at W=16.
      step(1'b1, 1'b1, 22'd1000, 19'd1000);
      #1;
      check("sat pos dout", 64'(d1), 64'h7FFF);
      check("sat pos ovf", 64'(ov_w[1]), 64'd1);
      step(1'b1, 1'b1, 22'h3FFC18, 19'd1000);
      #1;
      check("sat neg dout", 64'(d1), 64'h8000);
      check("sat neg ovf", 64'(ov_w[1]), 64'd1);
      step(1'b1, 1'b0, 22'h0, 19'h0);
      step(1'b1, 1'b0, 22'h0, 19'h0);
      #1;
      check("wrap dout", 64'(d2), 64'h4240);
      check("wrap ovf", 64'(ov_w[2]), 64'd1);
      check("wrap valid", 64'(dv_w[2]), 64'd1);

      // Shift by 4: round (u3, latency 2) versus floor (u4, latency 3).
      step(1'b1, 1'b1, 22'd5, 19'd5);
      step(1'b1, 1'b1, 22'h3FFFE8, 19'd1);
      #1;
      check("round 5x5", 64'(d3), 64'd2);
      step(1'b1, 1'b0, 22'h0, 19'h0);
      #1;
      check("round -24x1", 64'(d3), 64'hFFFF);
      check("trunc 5x5", 64'(d4), 64'd1);
      step(1'b1, 1'b0, 22'h0, 19'h0);
      #1;
      check("trunc -24x1", 64'(d4), 64'hFFFE);

      // Unsigned x unsigned, W=8, saturating.
      step(1'b1, 1'b1, 22'd20, 19'd20);
      step(1'b1, 1'b1, 22'd10, 19'd10);
      #1;
      check("uu 20x20 dout", 64'(d6), 64'hFF);
      check("uu 20x20 ovf", 64'(ov_w[6]), 64'd1);
      step(1'b1, 1'b0, 22'h0, 19'h0);
      #1;
      check("uu 10x10 dout", 64'(d6), 64'd100);
      check("uu 10x10 ovf", 64'(ov_w[6]), 64'd0);

      // Latency-3 stream with a two-cycle stall and a bubble.
      step(1'b1, 1'b1, 22'd1, 19'd1);
      step(1'b1, 1'b1, 22'd2, 19'd3);
      step(1'b0, 1'b1, 22'd7, 19'd7);
      step(1'b0, 1'b1, 22'd7, 19'd7);
      for (int j = 0; j < 4; j++) begin
         if (j == 1) step(1'b1, 1'b1, 22'd4, 19'd5);
         else        step(1'b1, 1'b0, 22'd9, 19'd9);
         #1;
         check($sformatf("stream valid %0d", j), 64'(dv_w[5]), 64'(sv_exp[j]));
         if (sv_exp[j]) check($sformatf("stream dout %0d", j), 64'(d5), 64'(sd_exp[j]));
      end

      // Asynchronous reset between edges with results in flight.
      step(1'b1, 1'b1, 22'd123, 19'd45);
      step(1'b1, 1'b1, 22'd67, 19'd89);
      #3;
      reset = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst u%0d valid", i), 64'(dv_w[i]), 64'd0);
         check($sformatf("rst u%0d dout", i), dd_w[i], 64'd0);
         check($sformatf("rst u%0d ovf", i), 64'(ov_w[i]), 64'd0);
      end
      n = 0;
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      ce        = 1'b0;
      din_valid = 1'b0;
      for (int j = 0; j < 6; j++) step(1'b1, 1'b0, rnd_a(), rnd_b());

      // Randomised traffic with random stalls and bubbles.
      for (int j = 0; j < 1500; j++) begin
         step(($urandom_range(0, 5) != 0), ($urandom_range(0, 3) != 0), rnd_a(), rnd_b());
      end
      @(negedge clk);
      check_all();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
